// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined ARM core.
//
// Holds the program counter, presents it combinationally to the instruction
// ROM and captures the returned word into the IF/ID pipeline register.
// It also handles stall, branch redirect, out-of-range fetch and the sticky
// fetch fault.
//
// Ports:
//   clk           in   core clock, all state updates on posedge
//   reset         in   synchronous active-high reset
//   instr_addr    out  [63:0] byte address to ROM (= PC)
//   instr_data    in   [31:0] ROM word for instr_addr, same cycle
//   stall         in   hold PC and IF/ID
//   branch_taken  in   redirect fetch this cycle (wins over stall)
//   branch_target in   [63:0] redirect byte address
//   ifid_pc       out  [63:0] PC of the instruction in IF/ID
//   ifid_instr    out  [31:0] instruction in IF/ID (NOP_WORD when bubble)
//   ifid_valid    out  IF/ID holds a real instruction
//   fetch_fault   out  sticky: PC left memory or branch target misaligned
//
// Build option: define FETCH_BRANCH_DELAY_SLOT_EN to keep the sequentially
// fetched word in IF/ID on a taken branch (one delay slot); otherwise the
// taken branch flushes IF/ID.

module fetch_stage #(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] NOP_WORD   = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_fault
);

    // PC + 3 < IMEM_BYTES rewritten as PC <= IMEM_BYTES - 4 so that a PC near
    // 2^64 cannot wrap the sum back into range.
    localparam logic [63:0] LAST_OK_PC = 64'(IMEM_BYTES) - 64'd4;

    logic [63:0] pc;
    logic        in_range;
    // Fetch is halted after a fault until a branch restarts it; kept separate
    // from fetch_fault because a restarting branch leaves the fault sticky.
    logic        halted;

    assign instr_addr = pc;
    assign in_range   = (pc <= LAST_OK_PC);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            ifid_pc     <= '0;
            ifid_instr  <= NOP_WORD;
            ifid_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            halted      <= 1'b0;
        end else if (branch_taken) begin
            pc      <= {branch_target[63:2], 2'b00};
            ifid_pc <= pc;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
            ifid_instr <= in_range ? instr_data : NOP_WORD;
            ifid_valid <= in_range;
`else
            ifid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
`endif
            if (branch_target[1:0] != 2'b00) begin
                fetch_fault <= 1'b1;
                halted      <= 1'b1;
            end else begin
                halted      <= 1'b0;
            end
        end else if (halted || !in_range) begin
            // Bubble with PC held; instr_data is never looked at here.
            ifid_pc     <= pc;
            ifid_instr  <= NOP_WORD;
            ifid_valid  <= 1'b0;
            fetch_fault <= 1'b1;
            halted      <= 1'b1;
        end else if (!stall) begin
            pc         <= pc + 64'd4;
            ifid_pc    <= pc;
            ifid_instr <= instr_data;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int unsigned IMEM  = 1024;
    localparam logic [31:0] NOP   = 32'hD503201F;
    localparam int unsigned WORDS = IMEM / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic [63:0] instr_addr;
    logic [31:0] instr_data;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_fault;

    logic [31:0] rom [WORDS];

    int errors = 0;
    int checks = 0;

    // Reference state: where fetch is and what IF/ID must hold.
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_fault, m_halt;

    fetch_stage #(.IMEM_BYTES(IMEM), .RESET_PC(64'h0), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_data(instr_data),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic addr_ok(input logic [63:0] a);
        return ({1'b0, a} + 65'd3) < 65'(IMEM);
    endfunction

    // Combinational ROM; garbage outside the array so it must never be captured.
    always_comb begin
        if (addr_ok(instr_addr)) instr_data = rom[instr_addr[9:2]];
        else                     instr_data = 32'hBAD0_BAD0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic b, input logic [63:0] t);
        logic ok;
        ok = addr_ok(m_pc);
        if (r) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_instr = NOP; m_valid = 1'b0;
            m_fault = 1'b0; m_halt = 1'b0;
        end else if (b) begin
            m_ipc = m_pc;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
            m_valid = ok;
            m_instr = ok ? rom[m_pc[9:2]] : NOP;
`else
            m_valid = 1'b0;
            m_instr = NOP;
`endif
            m_pc = t & ~64'd3;
            m_halt = (t % 4) != 0;
            if (m_halt) m_fault = 1'b1;
        end else if (m_halt || !ok) begin
            m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0;
            m_fault = 1'b1; m_halt = 1'b1;
        end else if (!s) begin
            m_ipc = m_pc; m_instr = rom[m_pc[9:2]]; m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic compare();
        chk("instr_addr",  instr_addr,  m_pc);
        chk("ifid_pc",     ifid_pc,     m_ipc);
        chk("ifid_instr",  64'(ifid_instr), 64'(m_instr));
        chk("ifid_valid",  64'(ifid_valid), 64'(m_valid));
        chk("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    endtask

    // Drive one cycle, advance the model at the edge, check just after.
    task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t);
        reset = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        model_edge(r, s, b, t);
        #1;
        compare();
    endtask

    task automatic free(); step(1'b0, 1'b0, 1'b0, 64'h0); endtask
    task automatic do_reset(); step(1'b1, 1'b0, 1'b0, 64'h0); endtask

    initial begin
        for (int i = 0; i < WORDS; i++) rom[i] = $urandom;

        // Reset state and straight-line fetch.
        do_reset(); do_reset();
        chk("rst_addr",  instr_addr, 64'h0);
        chk("rst_valid", 64'(ifid_valid), 64'h0);
        chk("rst_instr", 64'(ifid_instr), 64'(NOP));
        chk("rst_fault", 64'(fetch_fault), 64'h0);
        for (int k = 0; k < 4; k++) begin
            free();
            chk("seq_pc",    ifid_pc, 64'(4 * k));
            chk("seq_instr", 64'(ifid_instr), 64'(rom[k]));
            chk("seq_valid", 64'(ifid_valid), 64'h1);
        end
        chk("seq_addr",  instr_addr, 64'd16);
        chk("seq_fault", 64'(fetch_fault), 64'h0);

        // Stall held three cycles at PC=8.
        do_reset(); free(); free();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 64'h0);
            chk("stall_addr",  instr_addr, 64'd8);
            chk("stall_ifpc",  ifid_pc, 64'd4);
            chk("stall_instr", 64'(ifid_instr), 64'(rom[1]));
        end
        free();
        chk("unstall_ifpc",  ifid_pc, 64'd8);
        chk("unstall_instr", 64'(ifid_instr), 64'(rom[2]));
        chk("unstall_addr",  instr_addr, 64'd12);

        // Branch at PC=0x10 to 0x40.
        do_reset(); free(); free(); free(); free();
        step(1'b0, 1'b0, 1'b1, 64'h40);
        chk("br_addr", instr_addr, 64'h40);
        chk("br_ifpc", ifid_pc, 64'h10);
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
        chk("br_instr", 64'(ifid_instr), 64'(rom[4]));
        chk("br_valid", 64'(ifid_valid), 64'h1);
`else
        chk("br_instr", 64'(ifid_instr), 64'(NOP));
        chk("br_valid", 64'(ifid_valid), 64'h0);
`endif
        free();
        chk("br_next_ifpc",  ifid_pc, 64'h40);
        chk("br_next_instr", 64'(ifid_instr), 64'(rom[16]));
        chk("br_next_valid", 64'(ifid_valid), 64'h1);

        // Branch beats stall.
        step(1'b0, 1'b1, 1'b1, 64'h20);
        chk("br_stall_addr", instr_addr, 64'h20);

        // Run off the end of memory, then restart with a branch.
        step(1'b0, 1'b0, 1'b1, 64'd1016);
        free(); free();
        chk("last_ifpc",  ifid_pc, 64'd1020);
        chk("last_instr", 64'(ifid_instr), 64'(rom[255]));
        chk("last_valid", 64'(ifid_valid), 64'h1);
        chk("last_fault", 64'(fetch_fault), 64'h0);
        free();
        chk("oor_addr",  instr_addr, 64'd1024);
        chk("oor_valid", 64'(ifid_valid), 64'h0);
        chk("oor_instr", 64'(ifid_instr), 64'(NOP));
        chk("oor_fault", 64'(fetch_fault), 64'h1);
        free();
        chk("oor_hold_addr", instr_addr, 64'd1024);
        step(1'b0, 1'b0, 1'b1, 64'h0);
        free();
        chk("restart_ifpc",  ifid_pc, 64'h0);
        chk("restart_valid", 64'(ifid_valid), 64'h1);
        chk("restart_fault", 64'(fetch_fault), 64'h1);
        do_reset();
        chk("fault_clear", 64'(fetch_fault), 64'h0);

        // Misaligned target, then reset while stalled.
        free();
        step(1'b0, 1'b0, 1'b1, 64'h43);
        chk("mis_addr",  instr_addr, 64'h40);
        chk("mis_fault", 64'(fetch_fault), 64'h1);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("rst_stall_addr",  instr_addr, 64'h0);
        chk("rst_stall_valid", 64'(ifid_valid), 64'h0);
        chk("rst_stall_fault", 64'(fetch_fault), 64'h0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic r, s, b;
            logic [63:0] t;
            r = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 15))
                0:       t = 64'hFFFF_FFFF_FFFF_FFF8;
                1:       t = 64'd1012;
                default: t = 64'($urandom_range(0, 270)) * 4;
            endcase
            step(r, s, b, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
